// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
// Holds the word width, the countdown width and the FSM state encoding.
package data_mem_responder_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // All address bits take part in the check, so 0xFFFF never aliases into the array.
  function automatic logic addr_in_range(input logic [WORD_W-1:0] addr, input int words);
    return ({16'b0, addr} < 32'(words));
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU-to-responder request/response bundle for the MEM stage.
// The master side is the CPU; the slave side is data_mem_responder.
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic              req_valid;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;
  logic              stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );

endinterface

// File: rtl/data_mem_responder_mem_word_array.sv
// Single-port synchronous RAM of 16-bit words with a registered read.
// Contents are not reset; preload by hierarchical access.
module mem_word_array
  import data_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int AW        = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage responder: accepts one load/store, waits LATENCY cycles, then
// performs the access and returns a one-cycle response while raising stall.
//
// state  | meaning
// S_IDLE | no request outstanding, req_ready high
// S_WAIT | latency countdown running on the captured request
// S_RESP | response cycle, resp_valid high
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              hold_write;
  logic [WORD_W-1:0] hold_addr;
  logic [WORD_W-1:0] hold_wdata;

  logic              accept;
  logic              go_resp;
  logic              ready;
  logic              resp_valid;
  logic              resp_err;
  logic [WORD_W-1:0] resp_rdata;
  logic              stall;

  logic              acc_write;
  logic [WORD_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic              acc_ok;
  logic              hold_ok;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hold_write <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        hold_write <= bus.req_write;
        hold_addr  <= bus.req_addr;
        hold_wdata <= bus.req_wdata;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    accept     = 1'b0;
    go_resp    = 1'b0;
    ready      = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    stall      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        stall = bus.req_valid;
        if (bus.req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nx = S_RESP;
            go_resp  = 1'b1;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = CNT_W'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (cnt == '0) begin
          state_nx = S_RESP;
          go_resp  = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_RESP: begin
        stall      = bus.req_valid;
        resp_valid = 1'b1;
        resp_err   = !hold_ok;
        resp_rdata = (hold_write || !hold_ok) ? '0 : ram_rdata;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // With LATENCY=1 the access edge is also the capture edge, so the RAM
  // sees the request inputs directly; otherwise only the held copy.
  assign acc_write = (state == S_IDLE) ? bus.req_write : hold_write;
  assign acc_addr  = (state == S_IDLE) ? bus.req_addr  : hold_addr;
  assign acc_wdata = (state == S_IDLE) ? bus.req_wdata : hold_wdata;
  assign acc_ok    = addr_in_range(acc_addr, MEM_WORDS);
  assign hold_ok   = addr_in_range(hold_addr, MEM_WORDS);
  assign ram_we    = go_resp && acc_write && acc_ok && !reset;

  mem_word_array #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (acc_addr[AW-1:0]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_rdata;
  assign bus.resp_err   = resp_err;
  assign bus.stall      = stall;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY 1, 2 and 3 with
// hand-computed expectations for each cycle.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder_if m1 ();
  data_mem_responder_if m2 ();
  data_mem_responder_if m3 ();

  data_mem_responder #(.MEM_WORDS(256), .LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(m1.slave));
  data_mem_responder #(.MEM_WORDS(256), .LATENCY(2)) u_dut2 (.clk(clk), .reset(reset), .bus(m2.slave));
  data_mem_responder #(.MEM_WORDS(256), .LATENCY(3)) u_dut3 (.clk(clk), .reset(reset), .bus(m3.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req2(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    m2.req_valid = 1'b1;
    m2.req_write = wr;
    m2.req_addr  = addr;
    m2.req_wdata = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m1.req_valid = 0; m1.req_write = 0; m1.req_addr = 0; m1.req_wdata = 0;
    m2.req_valid = 0; m2.req_write = 0; m2.req_addr = 0; m2.req_wdata = 0;
    m3.req_valid = 0; m3.req_write = 0; m3.req_addr = 0; m3.req_wdata = 0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(m2.req_ready), 32'd1);
    chk("rst_valid", 32'(m2.resp_valid), 32'd0);
    chk("rst_rdata", 32'(m2.resp_rdata), 32'd0);
    chk("rst_err",   32'(m2.resp_err), 32'd0);
    chk("rst_stall", 32'(m2.stall), 32'd0);

    u_dut2.u_array.mem[8'h77] = 16'hDEAD;
    u_dut2.u_array.mem[8'hFF] = 16'h5A5A;
    u_dut2.u_array.mem[8'h02] = 16'h1111;
    u_dut2.u_array.mem[8'h31] = 16'h0000;
    u_dut1.u_array.mem[8'h10] = 16'h1234;
    u_dut1.u_array.mem[8'h11] = 16'h5678;
    u_dut3.u_array.mem[8'h00] = 16'hCAFE;

    // LATENCY=2 store then load
    req2(1'b1, 16'h0005, 16'hBEEF); #1;
    chk("st_c1_ready", 32'(m2.req_ready), 32'd1);
    chk("st_c1_stall", 32'(m2.stall), 32'd1);
    step(); m2.req_valid = 1'b0; #1;
    chk("st_c2_ready", 32'(m2.req_ready), 32'd0);
    chk("st_c2_stall", 32'(m2.stall), 32'd1);
    chk("st_c2_valid", 32'(m2.resp_valid), 32'd0);
    step();
    chk("st_c3_valid", 32'(m2.resp_valid), 32'd1);
    chk("st_c3_rdata", 32'(m2.resp_rdata), 32'd0);
    chk("st_c3_err",   32'(m2.resp_err), 32'd0);
    chk("st_c3_stall", 32'(m2.stall), 32'd0);
    step();
    req2(1'b0, 16'h0005, 16'h0000); #1;
    chk("ld_c4_ready", 32'(m2.req_ready), 32'd1);
    chk("ld_c4_valid", 32'(m2.resp_valid), 32'd0);
    step();
    m2.req_valid = 1'b0; m2.req_addr = 16'h0077; m2.req_write = 1'b1; m2.req_wdata = 16'h9999; #1;
    chk("ld_c5_valid", 32'(m2.resp_valid), 32'd0);
    step();
    chk("ld_c6_valid", 32'(m2.resp_valid), 32'd1);
    chk("ld_c6_rdata", 32'(m2.resp_rdata), 32'hBEEF);
    step();

    // Store with inputs altered during WAIT
    req2(1'b1, 16'h0030, 16'h3333);
    step();
    m2.req_valid = 1'b0; m2.req_addr = 16'h0031; m2.req_wdata = 16'h4444;
    step(); step();
    req2(1'b0, 16'h0030, 16'h0000);
    step(); m2.req_valid = 1'b0; step();
    chk("chg_ld30", 32'(m2.resp_rdata), 32'h3333);
    step();
    req2(1'b0, 16'h0031, 16'h0000);
    step(); m2.req_valid = 1'b0; step();
    chk("chg_ld31", 32'(m2.resp_rdata), 32'h0000);
    step();

    // Out of range
    req2(1'b0, 16'h0100, 16'h0000);
    step(); m2.req_valid = 1'b0; step();
    chk("oor_ld_valid", 32'(m2.resp_valid), 32'd1);
    chk("oor_ld_err",   32'(m2.resp_err), 32'd1);
    chk("oor_ld_rdata", 32'(m2.resp_rdata), 32'd0);
    step();
    req2(1'b1, 16'hFFFF, 16'hAAAA);
    step(); m2.req_valid = 1'b0; step();
    chk("oor_st_err",   32'(m2.resp_err), 32'd1);
    chk("oor_st_rdata", 32'(m2.resp_rdata), 32'd0);
    step();
    req2(1'b0, 16'h00FF, 16'h0000);
    step(); m2.req_valid = 1'b0; step();
    chk("oor_ff_err",   32'(m2.resp_err), 32'd0);
    chk("oor_ff_rdata", 32'(m2.resp_rdata), 32'h5A5A);
    step();

    // Reset during WAIT of a store
    req2(1'b1, 16'h0002, 16'h0F0F);
    step(); m2.req_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("rmid_valid", 32'(m2.resp_valid), 32'd0);
    chk("rmid_ready", 32'(m2.req_ready), 32'd1);
    reset = 1'b0;
    step();
    chk("rmid_valid2", 32'(m2.resp_valid), 32'd0);
    req2(1'b0, 16'h0002, 16'h0000);
    step(); m2.req_valid = 1'b0; step();
    chk("rmid_ld_valid", 32'(m2.resp_valid), 32'd1);
    chk("rmid_ld_rdata", 32'(m2.resp_rdata), 32'h1111);
    step();

    // LATENCY=1 back-to-back loads with req_valid held
    m1.req_valid = 1'b1; m1.req_write = 1'b0; m1.req_addr = 16'h0010; #1;
    chk("l1_c1_ready", 32'(m1.req_ready), 32'd1);
    chk("l1_c1_valid", 32'(m1.resp_valid), 32'd0);
    step();
    m1.req_addr = 16'h0011; #1;
    chk("l1_c2_ready", 32'(m1.req_ready), 32'd0);
    chk("l1_c2_valid", 32'(m1.resp_valid), 32'd1);
    chk("l1_c2_rdata", 32'(m1.resp_rdata), 32'h1234);
    chk("l1_c2_stall", 32'(m1.stall), 32'd1);
    step();
    chk("l1_c3_ready", 32'(m1.req_ready), 32'd1);
    chk("l1_c3_valid", 32'(m1.resp_valid), 32'd0);
    step();
    m1.req_valid = 1'b0; #1;
    chk("l1_c4_ready", 32'(m1.req_ready), 32'd0);
    chk("l1_c4_valid", 32'(m1.resp_valid), 32'd1);
    chk("l1_c4_rdata", 32'(m1.resp_rdata), 32'h5678);
    step();
    chk("l1_c5_ready", 32'(m1.req_ready), 32'd1);
    chk("l1_c5_valid", 32'(m1.resp_valid), 32'd0);

    // LATENCY=3 stall profile
    m3.req_valid = 1'b1; m3.req_write = 1'b0; m3.req_addr = 16'h0000; #1;
    chk("l3_c1_stall", 32'(m3.stall), 32'd1);
    step(); m3.req_valid = 1'b0; #1;
    chk("l3_c2_stall", 32'(m3.stall), 32'd1);
    chk("l3_c2_valid", 32'(m3.resp_valid), 32'd0);
    step();
    chk("l3_c3_stall", 32'(m3.stall), 32'd1);
    chk("l3_c3_valid", 32'(m3.resp_valid), 32'd0);
    step();
    chk("l3_c4_stall", 32'(m3.stall), 32'd0);
    chk("l3_c4_valid", 32'(m3.resp_valid), 32'd1);
    chk("l3_c4_rdata", 32'(m3.resp_rdata), 32'hCAFE);
    step();
    chk("l3_c5_valid", 32'(m3.resp_valid), 32'd0);
    chk("l3_c5_ready", 32'(m3.req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
